// File: rtl/axil_pkg.sv
// Shared AXI-Lite slave types: response codes, write/read FSM states and the
// byte-strobe merge helper used when AXIL_SLV_WSTRB_EN is defined.
package axil_pkg;

  typedef enum logic [1:0] {
    RESP_OKAY   = 2'b00,
    RESP_SLVERR = 2'b10
  } axil_resp_e;

  typedef enum logic [1:0] {
    WR_IDLE = 2'd0,
    WR_WAIT = 2'd1,
    WR_RESP = 2'd2
  } wr_state_e;

  typedef enum logic {
    RD_IDLE = 1'b0,
    RD_RESP = 1'b1
  } rd_state_e;

  function automatic logic [31:0] merge_strb(input logic [31:0] old_word,
                                             input logic [31:0] new_word,
                                             input logic [3:0]  strb);
    logic [31:0] res;
    res = old_word;
    for (int b = 0; b < 4; b++) begin
      if (strb[b]) res[8*b +: 8] = new_word[8*b +: 8];
    end
    return res;
  endfunction

endpackage

// File: rtl/axil_addr_decode.sv
// Combinational byte-address decode: in-range flag and word index relative
// to BASE_ADDR; the two low address bits are ignored.
module axil_addr_decode #(
  parameter int unsigned DEPTH     = 16,
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000
) (
  input  logic [31:0]              addr,
  output logic                     in_range,
  output logic [$clog2(DEPTH)-1:0] idx
);

  localparam int unsigned IDX_W = $clog2(DEPTH);

  logic [31:0] offset;
  logic        unused_lsb;

  // BASE_ADDR is aligned to 4*DEPTH, so the upper offset bits must all be zero.
  assign offset     = addr - BASE_ADDR;
  assign in_range   = (addr >= BASE_ADDR) && (offset[31:IDX_W+2] == '0);
  assign idx        = offset[IDX_W+1:2];
  assign unused_lsb = ^offset[1:0];

endmodule

// File: rtl/axil_slave_mem.sv
// AXI-Lite slave backed by a DEPTH x 32-bit register memory with independent
// write and read FSMs. Define AXIL_SLV_WSTRB_EN to honour wstrb byte lanes.
module axil_slave_mem
  import axil_pkg::*;
#(
  parameter int unsigned DEPTH     = 16,
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000
) (
  input  logic        aclk,
  input  logic        areset,
  input  logic [31:0] awaddr,
  input  logic [3:0]  awcache,
  input  logic [2:0]  awprot,
  input  logic        awvalid,
  output logic        awready,
  input  logic [31:0] wdata,
  input  logic [3:0]  wstrb,
  input  logic        wvalid,
  output logic        wready,
  output logic [1:0]  bresp,
  output logic        bvalid,
  input  logic        bready,
  input  logic [31:0] araddr,
  input  logic [3:0]  arcache,
  input  logic [2:0]  arprot,
  input  logic        arvalid,
  output logic        arready,
  output logic [31:0] rdata,
  output logic [1:0]  rresp,
  output logic        rvalid,
  input  logic        rready
);

  localparam int unsigned IDX_W = $clog2(DEPTH);

  // Handshakes: a beat transfers on an aclk edge where valid & ready are both
  // high; every ready here is a function of registered state only.
  wr_state_e   wr_state_q, wr_state_d;
  logic        aw_held_q, aw_held_d, w_held_q, w_held_d;
  logic [31:0] awaddr_q, awaddr_d, wdata_q, wdata_d;
  logic [3:0]  wstrb_q, wstrb_d;
  axil_resp_e  bresp_q, bresp_d;
  rd_state_e   rd_state_q, rd_state_d;
  logic [31:0] rdata_q, rdata_d;
  axil_resp_e  rresp_q, rresp_d;
  logic [31:0] mem_q [DEPTH];
  logic [31:0] mem_d [DEPTH];

  logic             aw_fire, w_fire, ar_fire;
  logic [31:0]      wr_addr_eff, wr_data_eff, wr_word;
  logic [3:0]       wr_strb_eff;
  logic             wr_in_range, rd_in_range;
  logic [IDX_W-1:0] wr_idx, rd_idx;
  logic             unused_ports;

  assign awready = (wr_state_q != WR_RESP) && !aw_held_q;
  assign wready  = (wr_state_q != WR_RESP) && !w_held_q;
  assign bvalid  = (wr_state_q == WR_RESP);
  assign bresp   = bresp_q;
  assign arready = (rd_state_q == RD_IDLE);
  assign rvalid  = (rd_state_q == RD_RESP);
  assign rdata   = rdata_q;
  assign rresp   = rresp_q;

  assign aw_fire = awvalid && awready;
  assign w_fire  = wvalid && wready;
  assign ar_fire = arvalid && arready;

  assign wr_addr_eff = aw_held_q ? awaddr_q : awaddr;
  assign wr_data_eff = w_held_q ? wdata_q : wdata;
  assign wr_strb_eff = w_held_q ? wstrb_q : wstrb;

  assign unused_ports = ^{awcache, awprot, arcache, arprot};

`ifdef AXIL_SLV_WSTRB_EN
  assign wr_word = merge_strb(mem_q[wr_idx], wr_data_eff, wr_strb_eff);
`else
  logic unused_strb;
  assign unused_strb = ^wr_strb_eff;
  assign wr_word     = wr_data_eff;
`endif

  axil_addr_decode #(.DEPTH(DEPTH), .BASE_ADDR(BASE_ADDR)) u_aw_decode (
    .addr     (wr_addr_eff),
    .in_range (wr_in_range),
    .idx      (wr_idx)
  );

  axil_addr_decode #(.DEPTH(DEPTH), .BASE_ADDR(BASE_ADDR)) u_ar_decode (
    .addr     (araddr),
    .in_range (rd_in_range),
    .idx      (rd_idx)
  );

  always_comb begin
    wr_state_d = wr_state_q;
    aw_held_d  = aw_held_q;
    w_held_d   = w_held_q;
    awaddr_d   = awaddr_q;
    wdata_d    = wdata_q;
    wstrb_d    = wstrb_q;
    bresp_d    = bresp_q;
    mem_d      = mem_q;
    unique case (wr_state_q)
      WR_IDLE, WR_WAIT: begin
        if ((aw_fire || aw_held_q) && (w_fire || w_held_q)) begin
          // Second of AW/W completes this edge: commit and respond next cycle.
          wr_state_d = WR_RESP;
          aw_held_d  = 1'b0;
          w_held_d   = 1'b0;
          if (wr_in_range) begin
            bresp_d        = RESP_OKAY;
            mem_d[wr_idx]  = wr_word;
          end else begin
            bresp_d = RESP_SLVERR;
          end
        end else begin
          if (aw_fire) begin
            aw_held_d = 1'b1;
            awaddr_d  = awaddr;
          end
          if (w_fire) begin
            w_held_d = 1'b1;
            wdata_d  = wdata;
            wstrb_d  = wstrb;
          end
          wr_state_d = (aw_held_d || w_held_d) ? WR_WAIT : WR_IDLE;
        end
      end
      WR_RESP: if (bready) wr_state_d = WR_IDLE;
      default: wr_state_d = WR_IDLE;
    endcase
  end

  // Reads sample mem_q, so a same-edge write to the same word is not visible.
  always_comb begin
    rd_state_d = rd_state_q;
    rdata_d    = rdata_q;
    rresp_d    = rresp_q;
    unique case (rd_state_q)
      RD_IDLE: begin
        if (ar_fire) begin
          rd_state_d = RD_RESP;
          rdata_d    = rd_in_range ? mem_q[rd_idx] : 32'h0;
          rresp_d    = rd_in_range ? RESP_OKAY : RESP_SLVERR;
        end
      end
      RD_RESP: if (rready) rd_state_d = RD_IDLE;
      default: rd_state_d = RD_IDLE;
    endcase
  end

  always_ff @(posedge aclk) begin
    if (areset) begin
      wr_state_q <= WR_IDLE;
      aw_held_q  <= 1'b0;
      w_held_q   <= 1'b0;
      awaddr_q   <= '0;
      wdata_q    <= '0;
      wstrb_q    <= '0;
      bresp_q    <= RESP_OKAY;
      rd_state_q <= RD_IDLE;
      rdata_q    <= '0;
      rresp_q    <= RESP_OKAY;
      mem_q      <= '{default: '0};
    end else begin
      wr_state_q <= wr_state_d;
      aw_held_q  <= aw_held_d;
      w_held_q   <= w_held_d;
      awaddr_q   <= awaddr_d;
      wdata_q    <= wdata_d;
      wstrb_q    <= wstrb_d;
      bresp_q    <= bresp_d;
      rd_state_q <= rd_state_d;
      rdata_q    <= rdata_d;
      rresp_q    <= rresp_d;
      mem_q      <= mem_d;
    end
  end

endmodule

// File: doc/axil_slave_mem.md
AXIL_SLAVE_MEM -- requirements
Module: axil_slave_mem

Interface
REQ-001 SHALL have parameter DEPTH, default 16, number of 32-bit words; power of two, 2..256.
REQ-002 SHALL have parameter BASE_ADDR, default 32'h0000_0000, byte address of word 0; aligned to 4*DEPTH.
REQ-003 SHALL have ports: aclk in 1, the single clock; areset in 1, synchronous active-high reset.
REQ-004 SHALL have ports awaddr in 32, awcache in 4, awprot in 3, awvalid in 1, awready out 1: write address channel.
REQ-005 SHALL have ports wdata in 32, wstrb in 4, wvalid in 1, wready out 1: write data channel.
REQ-006 SHALL have ports bresp out 2, bvalid out 1, bready in 1: write response channel.
REQ-007 SHALL have ports araddr in 32, arcache in 4, arprot in 3, arvalid in 1, arready out 1: read address channel.
REQ-008 SHALL have ports rdata out 32, rresp out 2, rvalid out 1, rready in 1: read data channel.

Function
REQ-009 SHALL act as the AXI-Lite slave consuming the master's five channels; awcache/awprot/arcache/arprot ignored.
REQ-010 SHALL treat an address as in range iff BASE_ADDR <= addr <= BASE_ADDR+4*DEPTH-1; word index = (addr-BASE_ADDR)>>2; addr[1:0] ignored.
REQ-011 SHALL run a write FSM: WR_IDLE -> WR_WAIT (only one of AW/W accepted) -> WR_RESP; WR_IDLE -> WR_RESP directly when AW and W both complete.
REQ-012 SHALL assert awready only while no address is held and bvalid=0; wready only while no data is held and bvalid=0; AW and W accepted independently, either order.
REQ-013 SHALL commit the write at the clock edge where the second of AW/W completes; bvalid=1 from the next cycle; in-range -> bresp=OKAY(2'b00), memory updated; out-of-range -> bresp=SLVERR(2'b10), memory unchanged.
REQ-014 SHALL hold bvalid and bresp stable until bvalid&bready, then return to WR_IDLE; a new AW/W is accepted no earlier than the cycle after that handshake.
REQ-015 SHALL run a read FSM: RD_IDLE (arready=1) -> RD_RESP on arvalid&arready; rvalid=1 on the next cycle with registered rdata/rresp.
REQ-016 SHALL return rresp=OKAY with stored word for in-range reads; rresp=SLVERR, rdata=32'h0 out of range.
REQ-017 SHALL hold rvalid/rdata/rresp stable until rvalid&rready; arready=0 in RD_RESP; return to RD_IDLE after handshake.
REQ-018 SHALL operate read and write FSMs concurrently; a read sampled at the same edge as a write commit to the same word returns the pre-write value.
REQ-019 SHALL never make any ready depend combinationally on the matching valid.

Reset
REQ-020 SHALL, on areset=1 at an aclk edge, force both FSMs idle, discard held AW/W, clear all memory words to 0.
REQ-021 SHALL drive during/after reset: awready=1, wready=1, arready=1, bvalid=0, rvalid=0, bresp=2'b00, rresp=2'b00, rdata=32'h0.
REQ-022 SHALL abort any in-flight transaction on reset mid-operation; no response is issued for it.

Configuration
REQ-023 SHALL honour byte strobes when AXIL_SLV_WSTRB_EN is defined: byte lane n written only if wstrb[n]=1; wstrb=4'h0 in range gives OKAY, no change.
REQ-024 SHALL, without AXIL_SLV_WSTRB_EN, ignore wstrb and write all 32 bits on every in-range write.

Structure
REQ-025 SHALL place in shared package axil_pkg: resp enum (OKAY=2'b00, SLVERR=2'b10), write-FSM and read-FSM state enums.
REQ-026 SHALL use one sub-module, axil_addr_decode (combinational: address -> in_range, word index), instantiated once per AW and AR path.

Verification
REQ-027 SHALL check: AW 0x8 and W 0xDEADBEEF same cycle, bready=1 -> bvalid next cycle, bresp=00; AR 0x8 -> rdata=0xDEADBEEF, rresp=00.
REQ-028 SHALL check: W 0x12345678 three cycles before AW 0x4 -> wready low after W accepted, commit on AW, bvalid one cycle later.
REQ-029 SHALL check: AW 0x40 (DEPTH=16) -> bresp=10, memory unchanged; AR 0x40 -> rresp=10, rdata=0.
REQ-030 SHALL check: bready/rready held low 5 cycles -> bvalid/rvalid, responses stable, awready/wready/arready low throughout.
REQ-031 SHALL check with AXIL_SLV_WSTRB_EN: word 0xFFFFFFFF, write 0x00000000 wstrb=4'b0101 -> read 0xFF00FF00; without macro -> read 0x00000000.
REQ-032 SHALL check: areset pulsed while bvalid=1 -> bvalid=0 next cycle, all readys 1, reads of word 2 return 0.
